// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch and load/store traffic.
// Round-robin arbitration, store lane formatting, load alignment/extension and core stall.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [2:0]        size_q, size_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              d_legal;
    logic [3:0]        st_strb;
    logic [DATA_W-1:0] st_wdata;
    logic [DATA_W-1:0] ld_lane;
    logic [DATA_W-1:0] ld_data;
    logic              want_if;
    logic              want_d;
    logic              pick_data;

    always_comb begin
        d_legal = 1'b0;
        case (d_size)
            3'b000, 3'b100: d_legal = 1'b1;
            3'b001, 3'b101: d_legal = ~d_addr[0];
            3'b010:         d_legal = (d_addr[1:0] == 2'b00);
            default:        d_legal = 1'b0;
        endcase
    end

    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = d_wdata;
        case (d_size[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << d_addr[1:0];
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = d_wdata;
            end
        endcase
    end

    // Shift the addressed byte/half down to bit 0 before extending.
    always_comb begin
        ld_lane = mem_rdata >> {addr_lo_q, 3'b000};
        ld_data = mem_rdata;
        case (size_q)
            3'b000:  ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
            3'b100:  ld_data = {24'h000000, ld_lane[7:0]};
            3'b001:  ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
            3'b101:  ld_data = {16'h0000, ld_lane[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    // A request whose ack is on the wire this cycle is already served; do not grant it again.
    assign want_if   = if_req & ~if_ack_q;
    assign want_d    = d_req & ~d_ack_q;
    assign pick_data = want_d & (~want_if | (last_grant_q == GRANT_FETCH));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (pick_data) begin
                    if (!d_legal) begin
                        state_d   = S_ERR;
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d     = S_DATA;
                        mem_valid_d = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_wstrb_d = d_we ? st_strb : 4'b0000;
                        addr_lo_d   = d_addr[1:0];
                        size_d      = d_size;
                    end
                end else if (want_if) begin
                    state_d     = S_FETCH;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = '0;
                    mem_wstrb_d = 4'b0000;
                    addr_lo_d   = if_addr[1:0];
                    size_d      = 3'b010;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    state_d      = S_IDLE;
                    last_grant_d = GRANT_FETCH;
                    mem_valid_d  = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    if_ack_d     = 1'b1;
                    if_rdata_d   = mem_rdata;
                end
            end
            S_DATA: begin
                if (mem_ready) begin
                    state_d      = S_IDLE;
                    last_grant_d = GRANT_DATA;
                    mem_valid_d  = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_wstrb_d  = 4'b0000;
                    d_ack_d      = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = ld_data;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                last_grant_d = GRANT_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_FETCH;
            addr_lo_q    <= 2'b00;
            size_q       <= 3'b000;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= 4'b0000;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed accesses, a responding memory model,
// and a monitor that checks memory requests and acks against expected queues.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;
    int mem_wait = 0;

    // ack entry: {is_data, err, check_rdata, rdata}
    logic [34:0] exp_q[$];
    // memory entry: {we, word_addr, wdata, wstrb}
    logic [68:0] mem_exp_q[$];
    logic [31:0] rd_q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .stall(stall), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // memory model: ready mem_wait cycles after mem_valid rises
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            tick();
            if (rst || !mem_valid) begin
                cnt = 0;
                mem_ready = 1'b0;
            end else if (cnt == mem_wait) begin
                cnt = 0;
                mem_ready = 1'b1;
                mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
            end else begin
                cnt++;
                mem_ready = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        logic        prev_valid;
        logic        prev_ready;
        logic [68:0] prev_req;
        logic [68:0] me;
        logic [34:0] ae;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_req   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_valid && !prev_ready && mem_valid) begin
                    tests++;
                    if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== prev_req) begin
                        fails++;
                        $display("FAIL mem_hold got=%h exp=%h", {mem_we, mem_addr, mem_wdata, mem_wstrb}, prev_req);
                    end
                end
                if (mem_valid && mem_ready) begin
                    tests++;
                    if (mem_exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL mem_unexpected got addr=%h we=%b exp none", mem_addr, mem_we);
                    end else begin
                        me = mem_exp_q.pop_front();
                        if (mem_we !== me[68] || mem_addr !== me[67:36] || mem_wstrb !== me[3:0] ||
                            (me[68] && mem_wdata !== me[35:4])) begin
                            fails++;
                            $display("FAIL mem_req got we=%b addr=%h wdata=%h wstrb=%b exp we=%b addr=%h wdata=%h wstrb=%b",
                                     mem_we, mem_addr, mem_wdata, mem_wstrb, me[68], me[67:36], me[35:4], me[3:0]);
                        end
                    end
                end
                if (if_ack || d_ack) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL ack_unexpected got if_ack=%b d_ack=%b exp none", if_ack, d_ack);
                    end else begin
                        ae = exp_q.pop_front();
                        if (if_ack && d_ack) begin
                            fails++;
                            $display("FAIL ack_both got if_ack=1 d_ack=1 exp one");
                        end else if (if_ack) begin
                            if (ae[34] !== 1'b0 || if_rdata !== ae[31:0]) begin
                                fails++;
                                $display("FAIL if_ack got rdata=%h exp is_data=%b rdata=%h", if_rdata, ae[34], ae[31:0]);
                            end
                        end else begin
                            if (ae[34] !== 1'b1 || d_err !== ae[33] || (ae[32] && d_rdata !== ae[31:0])) begin
                                fails++;
                                $display("FAIL d_ack got err=%b rdata=%h exp is_data=%b err=%b rdata=%h",
                                         d_err, d_rdata, ae[34], ae[33], ae[31:0]);
                            end
                        end
                    end
                end
            end
            prev_valid = mem_valid;
            prev_ready = mem_ready;
            prev_req   = {mem_we, mem_addr, mem_wdata, mem_wstrb};
        end
    end

    // scoreboard helpers
    task automatic expect_fetch(input logic [31:0] a, input logic [31:0] rd);
        mem_exp_q.push_back({1'b0, a[31:2], 2'b00, 32'h0, 4'b0000});
        rd_q.push_back(rd);
        exp_q.push_back({1'b0, 1'b0, 1'b1, rd});
    endtask

    task automatic expect_data(input logic we, input logic [31:0] a, input logic [31:0] memrd,
                               input logic [31:0] exp_rd, input logic err,
                               input logic [31:0] exp_wd, input logic [3:0] exp_strb);
        if (!err) begin
            mem_exp_q.push_back({we, a[31:2], 2'b00, exp_wd, exp_strb});
            rd_q.push_back(memrd);
        end
        exp_q.push_back({1'b1, err, (err | ~we), err ? 32'h0 : exp_rd});
    endtask

    // drivers
    task automatic fetch_req(input logic [31:0] a, output int cyc);
        if_addr = a;
        if_req  = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 60 && cyc == 0; i++) begin
            tick();
            if (if_ack) cyc = i + 1;
        end
        if_req = 1'b0;
        if (cyc == 0) begin
            tests++;
            fails++;
            $display("FAIL if_ack_timeout got none exp ack within 60 cycles");
        end
    endtask

    task automatic data_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, output int cyc);
        d_we    = we;
        d_size  = sz;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 60 && cyc == 0; i++) begin
            tick();
            if (d_ack) cyc = i + 1;
        end
        d_req = 1'b0;
        if (cyc == 0) begin
            tests++;
            fails++;
            $display("FAIL d_ack_timeout got none exp ack within 60 cycles");
        end
    endtask

    initial begin
        int cyc;
        int seen;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_size = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        tick();
        tick();
        check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_acks", {29'h0, if_ack, d_ack, d_err}, 32'h0);
        check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        check("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b0;
        tick();

        // fetch, memory ready 2 cycles after valid
        mem_wait = 2;
        expect_fetch(32'h100, 32'h00500093);
        fetch_req(32'h100, cyc);
        check("fetch_latency", cyc, 32'd4);
        tick();

        // loads
        mem_wait = 1;
        expect_data(1'b0, 32'h203, 32'h80FF1122, 32'hFFFFFF80, 1'b0, 32'h0, 4'b0000);
        data_req(1'b0, 3'b000, 32'h203, 32'h0, cyc);
        tick();
        expect_data(1'b0, 32'h203, 32'h80FF1122, 32'h00000080, 1'b0, 32'h0, 4'b0000);
        data_req(1'b0, 3'b100, 32'h203, 32'h0, cyc);
        tick();
        expect_data(1'b0, 32'h201, 32'h80FF1122, 32'h00000011, 1'b0, 32'h0, 4'b0000);
        data_req(1'b0, 3'b000, 32'h201, 32'h0, cyc);
        tick();
        expect_data(1'b0, 32'h202, 32'h80FF1122, 32'hFFFF80FF, 1'b0, 32'h0, 4'b0000);
        data_req(1'b0, 3'b001, 32'h202, 32'h0, cyc);
        tick();
        expect_data(1'b0, 32'h202, 32'h80FF1122, 32'h000080FF, 1'b0, 32'h0, 4'b0000);
        data_req(1'b0, 3'b101, 32'h202, 32'h0, cyc);
        tick();
        expect_data(1'b0, 32'h204, 32'h12345678, 32'h12345678, 1'b0, 32'h0, 4'b0000);
        data_req(1'b0, 3'b010, 32'h204, 32'h0, cyc);
        tick();

        // stores
        mem_wait = 0;
        expect_data(1'b1, 32'h12, 32'h0, 32'h0, 1'b0, 32'hABCDABCD, 4'b1100);
        data_req(1'b1, 3'b001, 32'h12, 32'h0000ABCD, cyc);
        tick();
        expect_data(1'b1, 32'h1, 32'h0, 32'h0, 1'b0, 32'h5A5A5A5A, 4'b0010);
        data_req(1'b1, 3'b000, 32'h1, 32'h1234565A, cyc);
        tick();
        expect_data(1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 4'b1111);
        data_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, cyc);
        tick();

        // illegal accesses: ack+err one cycle after the request, no memory traffic
        expect_data(1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000);
        data_req(1'b0, 3'b010, 32'h6, 32'h0, cyc);
        check("err_lw_latency", cyc, 32'd1);
        tick();
        expect_data(1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000);
        data_req(1'b0, 3'b111, 32'h6, 32'h0, cyc);
        check("err_size_latency", cyc, 32'd1);
        tick();
        expect_data(1'b1, 32'h3, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000);
        data_req(1'b1, 3'b001, 32'h3, 32'hFFFF, cyc);
        check("err_sh_latency", cyc, 32'd1);
        tick();

        // tie: last grant was DATA, so FETCH, DATA, FETCH with zero-wait memory
        expect_fetch(32'h300, 32'h11111111);
        expect_data(1'b0, 32'h400, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h0, 4'b0000);
        expect_fetch(32'h304, 32'h22222222);
        fork
            begin
                int c1;
                int c2;
                fetch_req(32'h300, c1);
                fetch_req(32'h304, c2);
            end
            begin
                int c3;
                data_req(1'b0, 3'b010, 32'h400, 32'h0, c3);
            end
            begin
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    check("tie_stall", {31'h0, stall}, (c < 6) ? 32'd1 : 32'd0);
                    check("tie_acks", {30'h0, if_ack, d_ack},
                          (c == 2 || c == 6) ? 32'd2 : ((c == 4) ? 32'd1 : 32'd0));
                end
            end
        join
        tick();

        // reset in the middle of a data access
        mem_wait = 20;
        d_we = 1'b0; d_size = 3'b010; d_addr = 32'h40; d_wdata = 32'h0;
        d_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (mem_valid) seen = 1;
        end
        check("rst_mid_valid_seen", seen, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("rst_mid_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_mid_d_ack", {31'h0, d_ack}, 32'h0);
        check("rst_mid_state", {30'h0, dbg_state}, 32'h0);
        check("rst_mid_stall_req", {31'h0, stall}, 32'h1);
        d_req = 1'b0;
        #1;
        check("rst_mid_stall_noreq", {31'h0, stall}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_idle", {30'h0, mem_valid, d_ack}, 32'h0);
        end

        check("exp_q_empty", exp_q.size(), 32'd0);
        check("mem_exp_q_empty", mem_exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
